// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
// Shared types and constants for the FIFO read-side streamer.
//   streamer_state_t : burst FSM states (IDLE, RUN, DRAIN, DONE)
//   SKID_DEPTH       : number of entries in the output skid buffer
//   skid_has_room()  : true while the skid can take another word
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } streamer_state_t;

   // Room check against the registered occupancy only, so callers never
   // pick up a path from the downstream ready.
   function automatic logic skid_has_room(input logic [1:0] count);
      return count < 2'(SKID_DEPTH);
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry FIFO-ordered skid buffer with a registered head.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   flush_i       : drop all entries on the next edge (wins over enq/deq)
//   enq_valid_i   : write enq_data_i this cycle (ignored when full and not draining)
//   enq_data_i    : data to enqueue
//   deq_ready_i   : downstream accepts the head this cycle
//   deq_valid_o   : head entry is valid (count != 0)
//   deq_data_o    : head entry, straight from a register
//   count_o       : current occupancy, 0..2
// Handshake: a word moves downstream on every cycle where
// deq_valid_o && deq_ready_i; deq_valid_o/deq_data_o stay put otherwise.
// -----------------------------------------------------------------------------
module stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              enq_valid_i,
   input  logic [DATA_W-1:0] enq_data_i,
   input  logic              deq_ready_i,
   output logic              deq_valid_o,
   output logic [DATA_W-1:0] deq_data_o,
   output logic [1:0]        count_o
);

   logic [DATA_W-1:0] entry0_q, entry0_d;   // head
   logic [DATA_W-1:0] entry1_q, entry1_d;   // second in line
   logic [1:0]        count_q,  count_d;
   logic              deq, enq;

   assign deq = (count_q != 2'd0) & deq_ready_i;
   // A write is only taken when there is room, or the head leaves this cycle.
   assign enq = enq_valid_i & (skid_has_room(count_q) | deq);

   always_comb begin
      entry0_d = entry0_q;
      entry1_d = entry1_q;
      count_d  = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         unique case ({enq, deq})
            2'b10: begin
               if (count_q == 2'd0) entry0_d = enq_data_i;
               else                 entry1_d = enq_data_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               entry0_d = entry1_q;
               count_d  = count_q - 2'd1;
            end
            2'b11: begin
               // Count unchanged; the new word goes behind whatever remains.
               if (count_q == 2'd1) begin
                  entry0_d = enq_data_i;
               end else begin
                  entry0_d = entry1_q;
                  entry1_d = enq_data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry0_q <= '0;
         entry1_q <= '0;
         count_q  <= 2'd0;
      end else begin
         entry0_q <= entry0_d;
         entry1_q <= entry1_d;
         count_q  <= count_d;
      end
   end

   assign deq_valid_o = (count_q != 2'd0);
   assign deq_data_o  = entry0_q;
   assign count_o     = count_q;

endmodule

// File: rtl/fifo_pop_streamer.sv
// -----------------------------------------------------------------------------
// fifo_pop_streamer
// Read-side engine for a synchronous FIFO: on start_i pops burst_len_i words
// through the pop/empty interface and forwards them on a valid/ready stream
// through a 2-entry skid buffer.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start_i          : start a burst (sampled only in IDLE)
//   burst_len_i      : words in the burst, latched with start_i (0 = empty burst)
//   fifo_empty_i     : FIFO empty flag
//   fifo_pop_data_i  : FIFO head data, valid while not empty
//   fifo_pop_o       : pop strobe, one word per high cycle
//   out_valid_o      : stream valid
//   out_data_o       : stream data
//   out_ready_i      : stream ready
//   busy_o           : high whenever the FSM is not IDLE
//   done_o           : one-cycle pulse when the burst completes
//   abort_i          : (FIFO_POP_STREAMER_ABORT_EN) abandon the running burst
//   aborted_o        : (FIFO_POP_STREAMER_ABORT_EN) high with done_o after an abort
//   dbg_state_o      : current FSM state, for observation only
// Optional feature macro: FIFO_POP_STREAMER_ABORT_EN.
// Handshake: a word is transferred on each cycle where out_valid_o &&
// out_ready_i; out_valid_o/out_data_o hold until that happens. fifo_pop_o is
// built from registered state plus fifo_empty_i, never from out_ready_i.
// -----------------------------------------------------------------------------
module fifo_pop_streamer
   import fifo_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  burst_len_i,
   input  logic              fifo_empty_i,
   input  logic [DATA_W-1:0] fifo_pop_data_i,
   output logic              fifo_pop_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic              busy_o,
   output logic              done_o,
`ifdef FIFO_POP_STREAMER_ABORT_EN
   input  logic              abort_i,
   output logic              aborted_o,
`endif
   output streamer_state_t   dbg_state_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   streamer_state_t  state_q, state_d;
   logic [CNT_W-1:0] pops_left_q, pops_left_d;   // words still to pop
   logic [CNT_W-1:0] sent_left_q, sent_left_d;   // words still to hand downstream
   logic [1:0]       skid_count;
   logic             pop;
   logic             deq_fire;
   logic             abort_req;

`ifdef FIFO_POP_STREAMER_ABORT_EN
   assign abort_req = abort_i & ((state_q == RUN) | (state_q == DRAIN));
`else
   assign abort_req = 1'b0;
`endif

   assign pop = (state_q == RUN) & ~fifo_empty_i & (pops_left_q != '0)
              & skid_has_room(skid_count) & ~abort_req;
   assign deq_fire = out_valid_o & out_ready_i;

   // ---------------------------------------------------------------------------
   // Burst FSM and counters
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pops_left_d = pops_left_q;
      sent_left_d = sent_left_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               pops_left_d = burst_len_i;
               sent_left_d = burst_len_i;
               state_d     = (burst_len_i != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (abort_req) begin
               pops_left_d = '0;
               sent_left_d = '0;
               state_d     = DONE;
            end else begin
               if (pop) begin
                  pops_left_d = pops_left_q - CNT_ONE;
                  if (pops_left_q == CNT_ONE) state_d = DRAIN;
               end
               // Earlier words can reach downstream while later ones are
               // still being popped.
               if (deq_fire && (sent_left_q != '0)) begin
                  sent_left_d = sent_left_q - CNT_ONE;
               end
            end
         end
         DRAIN: begin
            if (abort_req) begin
               pops_left_d = '0;
               sent_left_d = '0;
               state_d     = DONE;
            end else if (deq_fire && (sent_left_q != '0)) begin
               sent_left_d = sent_left_q - CNT_ONE;
               if (sent_left_q == CNT_ONE) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pops_left_q <= '0;
         sent_left_q <= '0;
      end else begin
         state_q     <= state_d;
         pops_left_q <= pops_left_d;
         sent_left_q <= sent_left_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Abort flag: set on the abort edge, so it lines up with the DONE cycle.
   // ---------------------------------------------------------------------------
`ifdef FIFO_POP_STREAMER_ABORT_EN
   logic aborted_q, aborted_d;

   always_comb begin
      aborted_d = aborted_q;
      if (state_q == DONE) aborted_d = 1'b0;
      else if (abort_req)  aborted_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) aborted_q <= 1'b0;
      else       aborted_q <= aborted_d;
   end

   assign aborted_o = aborted_q;
`endif

   // ---------------------------------------------------------------------------
   // Output skid buffer: popped data is captured on the pop edge. An abort
   // flushes it on the same edge that moves the FSM to DONE.
   // ---------------------------------------------------------------------------
   stream_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (abort_req),
      .enq_valid_i (pop),
      .enq_data_i  (fifo_pop_data_i),
      .deq_ready_i (out_ready_i),
      .deq_valid_o (out_valid_o),
      .deq_data_o  (out_data_o),
      .count_o     (skid_count)
   );

   assign fifo_pop_o  = pop;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_pop_streamer.sv
`timescale 1ns/1ps
module tb_fifo_pop_streamer;
   import fifo_stream_pkg::*;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic              start_i = 1'b0;
   logic [CNT_W-1:0]  burst_len_i = '0;
   logic              fifo_empty_i = 1'b1;
   logic [DATA_W-1:0] fifo_pop_data_i = '0;
   logic              fifo_pop_o;
   logic              out_valid_o;
   logic [DATA_W-1:0] out_data_o;
   logic              out_ready_i = 1'b0;
   logic              busy_o;
   logic              done_o;
   logic              abort_i = 1'b0;
   logic              aborted_o;
   streamer_state_t   dbg_state;

   fifo_pop_streamer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .burst_len_i     (burst_len_i),
      .fifo_empty_i    (fifo_empty_i),
      .fifo_pop_data_i (fifo_pop_data_i),
      .fifo_pop_o      (fifo_pop_o),
      .out_valid_o     (out_valid_o),
      .out_data_o      (out_data_o),
      .out_ready_i     (out_ready_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
`ifdef FIFO_POP_STREAMER_ABORT_EN
      .abort_i         (abort_i),
      .aborted_o       (aborted_o),
`endif
      .dbg_state_o     (dbg_state)
   );

`ifndef FIFO_POP_STREAMER_ABORT_EN
   assign aborted_o = 1'b0;
`endif

   // ---------------------------------------------------------------- counters
   int checks = 0;
   int errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- FIFO environment
   logic [DATA_W-1:0] src_q[$];
   int  ready_mode = 1;      // 0 low, 1 high, 2 random
   bit  rand_empty = 1'b0;
   bit  refill_en  = 1'b0;
   bit  pop_seen   = 1'b0;
   logic [DATA_W-1:0] junk;

   always @(posedge clk) begin
      bit do_pop;
      do_pop = pop_seen && !reset;
      #1;
      if (do_pop && src_q.size() > 0) junk = src_q.pop_front();
      if (refill_en) while (src_q.size() < 4) src_q.push_back(DATA_W'($urandom));
      case (ready_mode)
         0:       out_ready_i = 1'b0;
         1:       out_ready_i = 1'b1;
         default: out_ready_i = ($urandom_range(0, 2) != 0);
      endcase
      fifo_empty_i = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 3) == 0));
      fifo_pop_data_i = (src_q.size() > 0) ? src_q[0] : '0;
   end

   // ---------------------------------------------------------------- reference model + scoreboard
   // Words popped but not yet delivered, in order.
   logic [DATA_W-1:0] exp_q[$];
   bit m_active = 1'b0;   // burst running (popping or draining)
   bit m_done   = 1'b0;   // completion cycle
   bit m_abort  = 1'b0;
   int m_len = 0, m_popped = 0, m_sent = 0;

   // logs for directed checks
   int cyc = 0;
   int pops_cnt = 0, done_cnt = 0, valid_cyc = 0;
   int first_pop_cyc = -1, last_pop_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
   logic [DATA_W-1:0] deliv_q[$];

   always @(negedge clk) begin
      bit exp_pop, exp_valid, abort_now, deq;
      cyc++;
      if (reset) begin
         chk1("rst_pop", fifo_pop_o, 1'b0);
         chk1("rst_valid", out_valid_o, 1'b0);
         chk8("rst_data", out_data_o, '0);
         chk1("rst_busy", busy_o, 1'b0);
         chk1("rst_done", done_o, 1'b0);
         chk1("rst_aborted", aborted_o, 1'b0);
         chkn("rst_state", int'(dbg_state), int'(IDLE));
         exp_q.delete();
         m_active = 1'b0; m_done = 1'b0; m_abort = 1'b0;
         pop_seen = 1'b0;
      end else begin
`ifdef FIFO_POP_STREAMER_ABORT_EN
         abort_now = abort_i && m_active;
`else
         abort_now = 1'b0;
`endif
         exp_valid = (exp_q.size() != 0);
         exp_pop   = m_active && !fifo_empty_i && (m_popped < m_len)
                   && (exp_q.size() < 2) && !abort_now;
         chk1("pop", fifo_pop_o, exp_pop);
         chk1("valid", out_valid_o, exp_valid);
         chk1("busy", busy_o, m_active || m_done);
         chk1("done", done_o, m_done);
         chk1("aborted", aborted_o, m_done && m_abort);
         if (exp_valid) chk8("data", out_data_o, exp_q[0]);

         if (fifo_pop_o) begin
            if (pops_cnt == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pops_cnt++;
         end
         if (out_valid_o) begin
            if (valid_cyc == 0) first_valid_cyc = cyc;
            valid_cyc++;
         end
         if (out_valid_o && out_ready_i) deliv_q.push_back(out_data_o);
         if (done_o) begin done_cnt++; done_cyc = cyc; end
         pop_seen = fifo_pop_o;

         // advance model to the next cycle
         deq = exp_valid && out_ready_i;
         if (m_done) begin
            m_done = 1'b0; m_abort = 1'b0;
         end else if (!m_active) begin
            if (start_i) begin
               m_len = int'(burst_len_i); m_popped = 0; m_sent = 0;
               if (m_len == 0) m_done = 1'b1;
               else            m_active = 1'b1;
            end
         end else if (abort_now) begin
            m_active = 1'b0; m_done = 1'b1; m_abort = 1'b1;
            exp_q.delete();
         end else begin
            if (deq) begin junk = exp_q.pop_front(); m_sent++; end
            if (exp_pop) begin exp_q.push_back(fifo_pop_data_i); m_popped++; end
            if (m_sent == m_len) begin m_active = 1'b0; m_done = 1'b1; end
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   int start_cyc = 0;

   task automatic clear_logs();
      pops_cnt = 0; done_cnt = 0; valid_cyc = 0;
      first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
      deliv_q.delete();
   endtask

   task automatic start_burst(input int len);
      @(posedge clk); #2;
      start_i = 1'b1;
      burst_len_i = CNT_W'(len);
      start_cyc = cyc;
      @(posedge clk); #2;
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy_o && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      chk1({name, "_idle_timeout"}, busy_o, 1'b0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_deliv(input string name, input logic [DATA_W-1:0] w[$]);
      chkn({name, "_count"}, deliv_q.size(), w.size());
      for (int i = 0; i < w.size() && i < deliv_q.size(); i++)
         chk8($sformatf("%s_w%0d", name, i), deliv_q[i], w[i]);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [DATA_W-1:0] w1[$], w2[$], w3[$], w5[$];
      logic [DATA_W-1:0] nx0, nx1;
      int n;

      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      idle_cycles(2);

      // 1: len=4, FIFO holds A1..A4, ready high
      w1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      src_q = w1; ready_mode = 1;
      idle_cycles(2); clear_logs();
      start_burst(4);
      wait_idle("t1", 40);
      chkn("t1_pops", pops_cnt, 4);
      chkn("t1_consecutive", last_pop_cyc - first_pop_cyc, 3);
      chkn("t1_latency", first_valid_cyc - first_pop_cyc, 1);
      chkn("t1_done_pulses", done_cnt, 1);
      check_deliv("t1", w1);

      // 2: len=6 with ready low for 5 cycles
      w2 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
      ready_mode = 0; src_q = w2;
      idle_cycles(2); clear_logs();
      start_burst(6);
      idle_cycles(4);
      chkn("t2_pops_stalled", pops_cnt, 2);
      chk1("t2_pop_low", fifo_pop_o, 1'b0);
      chk1("t2_valid_held", out_valid_o, 1'b1);
      chk8("t2_data_held", out_data_o, 8'hB0);
      ready_mode = 1;
      wait_idle("t2", 60);
      chkn("t2_pops", pops_cnt, 6);
      check_deliv("t2", w2);

      // 3: len=3, FIFO runs dry after the first word
      w3 = '{8'hC0, 8'hC1, 8'hC2};
      src_q.delete(); src_q.push_back(8'hC0);
      idle_cycles(2); clear_logs();
      start_burst(3);
      idle_cycles(3);
      chkn("t3_pops_while_empty", pops_cnt, 1);
      chk1("t3_busy_stalled", busy_o, 1'b1);
      src_q.push_back(8'hC1); src_q.push_back(8'hC2);
      wait_idle("t3", 40);
      chkn("t3_pops", pops_cnt, 3);
      check_deliv("t3", w3);
      src_q.push_back(8'hCC);
      idle_cycles(4);
      chkn("t3_no_extra_pop", pops_cnt, 3);
      src_q.delete();

      // 4: len=0
      idle_cycles(2); src_q.push_back(8'hEE); idle_cycles(1); clear_logs();
      start_burst(0);
      wait_idle("t4", 10);
      chkn("t4_pops", pops_cnt, 0);
      chkn("t4_valid_cycles", valid_cyc, 0);
      chkn("t4_done_pulses", done_cnt, 1);
      chkn("t4_done_offset", done_cyc - start_cyc, 2);
      src_q.delete();

      // 5: reset during word 2 of len=5, then len=2
      for (int i = 0; i < 8; i++) src_q.push_back(DATA_W'(8'hD0 + i));
      idle_cycles(2); clear_logs();
      start_burst(5);
      n = 0;
      while (deliv_q.size() < 1 && n < 40) begin @(posedge clk); n++; end
      chkn("t5_first_word_seen", deliv_q.size(), 1);
      #3 reset = 1'b1;
      #1;
      chk1("t5_async_pop", fifo_pop_o, 1'b0);
      chk1("t5_async_valid", out_valid_o, 1'b0);
      chk8("t5_async_data", out_data_o, '0);
      chk1("t5_async_busy", busy_o, 1'b0);
      chk1("t5_async_done", done_o, 1'b0);
      nx0 = src_q[0]; nx1 = src_q[1];
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      chkn("t5_no_done_on_reset", done_cnt, 0);
      w5 = '{nx0, nx1};
      idle_cycles(2); clear_logs();
      start_burst(2);
      wait_idle("t5", 30);
      chkn("t5_pops", pops_cnt, 2);
      chkn("t5_done_pulses", done_cnt, 1);
      check_deliv("t5", w5);
      src_q.delete();

`ifdef FIFO_POP_STREAMER_ABORT_EN
      // 6: abort after 2 of 8 pops with ready low
      for (int i = 0; i < 8; i++) src_q.push_back(DATA_W'(8'h60 + i));
      ready_mode = 0;
      idle_cycles(2); clear_logs();
      start_burst(8);
      idle_cycles(3);
      chkn("t6_pops_before_abort", pops_cnt, 2);
      abort_i = 1'b1;
      @(posedge clk); #2;
      abort_i = 1'b0;
      chk1("t6_valid_flushed", out_valid_o, 1'b0);
      chk1("t6_done", done_o, 1'b1);
      chk1("t6_aborted", aborted_o, 1'b1);
      @(posedge clk); #2;
      chk1("t6_done_one_cycle", done_o, 1'b0);
      chk1("t6_aborted_one_cycle", aborted_o, 1'b0);
      chkn("t6_pops", pops_cnt, 2);
      ready_mode = 1; src_q.delete();
`endif

      // 7: maximum burst length
      refill_en = 1; ready_mode = 1;
      idle_cycles(2); clear_logs();
      start_burst(255);
      wait_idle("t7", 700);
      chkn("t7_pops", pops_cnt, 255);
      chkn("t7_delivered", deliv_q.size(), 255);
      chkn("t7_done_pulses", done_cnt, 1);

      // 8: random traffic, model checks every cycle
      ready_mode = 2; rand_empty = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         start_i = ($urandom_range(0, 5) == 0);
         burst_len_i = ($urandom_range(0, 39) == 0) ? CNT_W'($urandom_range(0, 255))
                                                     : CNT_W'($urandom_range(0, 6));
`ifdef FIFO_POP_STREAMER_ABORT_EN
         abort_i = ($urandom_range(0, 29) == 0);
`endif
      end
      @(posedge clk); #2;
      start_i = 1'b0; abort_i = 1'b0; ready_mode = 1;
      wait_idle("t8", 700);
      idle_cycles(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
